// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit words and
// streams them, each with an auto-incrementing write address, out of a
// small FIFO toward the instruction-memory write port.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               opcode,
  input  logic [2:0]               rd,
  input  logic [2:0]               rs1,
  input  logic [2:0]               rs2,
  input  logic [7:0]               immediate,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     restart,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Opcode map used by the field-forcing and format selection below.
  localparam logic [3:0] OP_ST      = 4'b0000;
  localparam logic [3:0] OP_LDI     = 4'b0001;
  localparam logic [3:0] OP_LD      = 4'b0010;
  localparam logic [3:0] OP_JE      = 4'b0011;
  localparam logic [3:0] OP_JMP     = 4'b0100;
  localparam logic [3:0] OP_JNE     = 4'b0101;
  localparam logic [3:0] OP_JC      = 4'b0110;
  localparam logic [3:0] OP_ILLEGAL = 4'b0111;
  localparam logic [3:0] OP_INC     = 4'b1010;
  localparam logic [3:0] OP_DEC     = 4'b1011;
  localparam logic [3:0] OP_NOP     = 4'b1111;

  // FIFO storage: each slot holds an encoded word and its write address.
  logic [15:0]       mem_instr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q  [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [15:0]       head_instr_q, head_instr_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;

  logic [15:0]       enc_word;
  logic              is_iform;
  logic              is_illegal;
  logic [2:0]        rd_f;
  logic [2:0]        rs1_f;
  logic [2:0]        rs2_f;

  logic              accept;
  logic              push;
  logic              pop;
  logic [CW-1:0]     remaining;

  // Encode the presented field bundle, zeroing fields the opcode does not use.
  always_comb begin
    rd_f       = rd;
    rs1_f      = rs1;
    rs2_f      = rs2;
    is_iform   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ST:  rd_f = 3'b000;
      OP_LD, OP_INC, OP_DEC, OP_NOP: rs2_f = 3'b000;
      OP_LDI: is_iform = 1'b1;
      OP_JE, OP_JMP, OP_JNE, OP_JC: begin
        is_iform = 1'b1;
        rs1_f    = 3'b000;
      end
      OP_ILLEGAL: is_illegal = 1'b1;
      default: ;
    endcase
    if (is_iform) begin
      enc_word = {immediate, 1'b0, rs1_f, opcode};
    end else begin
      enc_word = {3'b000, rd_f, rs2_f, rs1_f, opcode};
    end
  end

  // Handshake: a same-cycle pop frees a slot, and restart blocks intake.
  always_comb begin
    out_valid = (count_q != '0);
    in_ready  = !restart && ((count_q < CW'(DEPTH)) || (out_valid && out_ready));
    accept    = in_valid && in_ready;
    push      = accept && !is_illegal;
    pop       = out_valid && out_ready && !restart;
  end

  // Next-state for pointers, occupancy, address counter, error flag and head.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    addr_d       = addr_q;
    err_d        = err_q;
    head_instr_d = head_instr_q;
    head_addr_d  = head_addr_q;
    remaining    = count_q;
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = base_addr;
      err_d    = 1'b0;
    end else begin
      if (accept && is_illegal) begin
        err_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        addr_d   = addr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        remaining = count_q - CW'(1);
      end
      count_d = remaining + CW'(push);
      if (push || pop) begin
        if (remaining != '0) begin
          head_instr_d = mem_instr_q[rd_ptr_d];
          head_addr_d  = mem_addr_q[rd_ptr_d];
        end else if (push) begin
          head_instr_d = enc_word;
          head_addr_d  = addr_q;
        end
      end
    end
  end

  // Write accepted legal words with their address into the FIFO slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_addr_q[i]  <= '0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= enc_word;
      mem_addr_q[wr_ptr_q]  <= addr_q;
    end
  end

  // Register control state and the FIFO head presented on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      head_instr_q <= '0;
      head_addr_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      head_instr_q <= head_instr_d;
      head_addr_q  <= head_addr_d;
    end
  end

  assign out_instr   = head_instr_q;
  assign out_addr    = head_addr_q;
  assign count       = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed steps with a scoreboard of
// expected (word, address) pairs consumed by an output monitor.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [7:0]  immediate;
  logic [7:0]  base_addr;
  logic        restart;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  count;
  logic        err_illegal;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_addr;
  logic [23:0] sb [$];

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .base_addr(base_addr), .restart(restart), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding built from the word-format tables.
  function automatic logic [15:0] model_enc(input logic [3:0] op, input logic [2:0] d,
                                            input logic [2:0] s1, input logic [2:0] s2,
                                            input logic [7:0] imm);
    case (op)
      4'h1:                   return {imm, 1'b0, s1, op};
      4'h3, 4'h4, 4'h5, 4'h6: return {imm, 4'b0000, op};
      4'h0:                   return {6'b000000, s2, s1, op};
      4'h2, 4'hA, 4'hB, 4'hF: return {3'b000, d, 3'b000, s1, op};
      default:                return {3'b000, d, s2, s1, op};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every word leaving the FIFO against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !restart && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_word: observed %h@%h expected none", out_instr, out_addr);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("out_instr", 32'(out_instr), 32'(e[23:8]));
        check("out_addr", 32'(out_addr), 32'(e[7:0]));
      end
    end
  end

  // Present one bundle, wait (bounded) for acceptance, record expectation.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                               input logic [2:0] s2, input logic [7:0] imm);
    int waited;
    in_valid = 1'b1; opcode = op; rd = d; rs1 = s1; rs2 = s2; immediate = imm;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
    end else if (op != 4'h7) begin
      sb.push_back({model_enc(op, d, s1, s2, imm), exp_addr});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic doRestart(input logic [7:0] base);
    @(posedge clk); #1;
    restart = 1'b1; base_addr = base;
    #1 check("in_ready_restart", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    restart = 1'b0;
    exp_addr = base;
  endtask

  task automatic checkOutput();
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_addr = 8'h00;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    immediate = '0; base_addr = '0; restart = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] step 1: R-format after restart");
    doRestart(8'h10);
    out_ready = 1'b1;
    applyStimulus(4'b1000, 3'b001, 3'b010, 3'b011, 8'h00);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("add_word", 32'(out_instr), 32'h05A8);
    check("add_addr", 32'(out_addr), 32'h10);
    checkOutput();

    $display("[TB] step 2: I-format and forced fields");
    applyStimulus(4'b0100, 3'b111, 3'b101, 3'b110, 8'hAA);
    applyStimulus(4'b0001, 3'b011, 3'b010, 3'b001, 8'h5C);
    checkOutput();
    applyStimulus(4'b1010, 3'b011, 3'b100, 3'b111, 8'h00);
    check("inc_word", 32'(out_instr), 32'h0C4A);
    applyStimulus(4'b0000, 3'b111, 3'b001, 3'b010, 8'h33);
    checkOutput();

    $display("[TB] step 3/4: backpressure and full push-pop");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(4'b1001, 3'(i), 3'(i + 1), 3'(i + 2), 8'h00);
    in_valid = 1'b1; opcode = 4'b1100; rd = 3'd5; rs1 = 3'd6; rs2 = 3'd7;
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("held_instr", 32'(out_instr), 32'(sb[0][23:8]));
    @(negedge clk);
    check("held_instr2", 32'(out_instr), 32'(sb[0][23:8]));
    out_ready = 1'b1;
    #1 check("pop_frees_slot", 32'(in_ready), 32'd1);
    sb.push_back({model_enc(4'b1100, 3'd5, 3'd6, 3'd7, 8'h00), exp_addr});
    exp_addr = exp_addr + 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pushpop_count", 32'(count), 32'd4);
    checkOutput();

    $display("[TB] step 5: illegal opcode");
    applyStimulus(4'b1000, 3'd1, 3'd2, 3'd3, 8'h00);
    applyStimulus(4'b0111, 3'd4, 3'd5, 3'd6, 8'hFF);
    applyStimulus(4'b1101, 3'd7, 3'd6, 3'd5, 8'h00);
    checkOutput();
    check("err_set", 32'(err_illegal), 32'd1);
    out_ready = 1'b0;
    applyStimulus(4'b1110, 3'd1, 3'd1, 3'd1, 8'h00);
    sb.delete();
    doRestart(8'h00);
    check("err_cleared", 32'(err_illegal), 32'd0);
    check("restart_count", 32'(count), 32'd0);

    $display("[TB] step 6: reset mid-stream and address wrap");
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b1000, 3'(i), 3'd1, 3'd2, 8'h00);
    sb.delete();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr", 32'(out_instr), 32'd0);
    check("mid_rst_addr", 32'(out_addr), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr = 8'h00;
    out_ready = 1'b1;
    applyStimulus(4'b1001, 3'd2, 3'd3, 3'd4, 8'h00);
    check("post_rst_addr", 32'(out_addr), 32'd0);
    checkOutput();
    doRestart(8'hFF);
    applyStimulus(4'b0011, 3'd0, 3'd3, 3'd0, 8'h12);
    applyStimulus(4'b0010, 3'd6, 3'd5, 3'd4, 8'h00);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
